// File: rtl/sqrt_prenorm.sv
// ============================================================================
// Module  : sqrt_prenorm
// Brief   : Even-shift normaliser feeding the 12-bit bipartite sqrt table.
//           Optional macro SQRT_PRENORM_RND_EN rounds out_a to nearest.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module sqrt_prenorm #(
  parameter int WIDTH = 24,
  parameter int KW    = $clog2(WIDTH/2+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_a,
  output logic [KW-1:0]    out_k,
  output logic             out_zero,
  output logic             out_inexact
);

  localparam int SW = $clog2(WIDTH+1);

  logic             s1_valid;
  logic [WIDTH-1:0] s1_x;
  logic [SW-1:0]    s1_s;
  logic             s1_zero;

  logic             s1_adv;
  logic             s2_adv;
  logic [SW-1:0]    lz;
  logic [SW-1:0]    shift;
  logic [WIDTH-1:0] n;
  logic [SW-1:0]    k_full;
  logic [11:0]      a_next;
  logic             inexact_next;

  assign s2_adv   = !out_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;

  // Highest set bit wins because it is visited last; all-zero leaves WIDTH.
  always_comb begin
    lz = SW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (in_x[i]) lz = SW'(WIDTH - 1 - i);
    end
  end

  assign shift = lz & ~SW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_x     <= '0;
      s1_s     <= '0;
      s1_zero  <= 1'b0;
    end else if (s1_adv) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_x    <= in_x;
        s1_s    <= shift;
        s1_zero <= (in_x == '0);
      end
    end
  end

  assign n            = s1_x << s1_s;
  assign k_full       = SW'(WIDTH) - s1_s;
  assign inexact_next = |n[WIDTH-13:0];

`ifdef SQRT_PRENORM_RND_EN
  logic [12:0] a_sum;
  assign a_sum  = {1'b0, n[WIDTH-1 -: 12]} + 13'(n[WIDTH-13]);
  assign a_next = a_sum[12] ? 12'hFFF : a_sum[11:0];
`else
  assign a_next = n[WIDTH-1 -: 12];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_a       <= '0;
      out_k       <= '0;
      out_zero    <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_zero <= s1_zero;
        if (s1_zero) begin
          out_a       <= '0;
          out_k       <= '0;
          out_inexact <= 1'b0;
        end else begin
          out_a       <= a_next;
          out_k       <= KW'(k_full >> 1);
          out_inexact <= inexact_next;
        end
      end
    end
  end

endmodule

`default_nettype wire
